aes_spi_frame_slave: RTL and testbench

SPI slave and frame decoder on the encryption side of the SPI link. It deserializes the byte stream from the SPI master: 16 plaintext bytes, one key-size byte, then the key bytes. It then presents the assembled text and key to the AES core with a start pulse, captures the core result, and shifts the 16 result bytes back out on MISO. It sits directly downstream of the master's SPI pins and directly upstream of the AES encrypt core.

---
 rtl/aes_spi_frame_slave.sv | 233 +++++++++++++++++++++++
 tb/tb_aes_spi_frame_slave.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_frame_slave.sv
// rtl/aes_spi_frame_slave.sv - SPI mode-0 slave that assembles AES text/key frames and returns the core result.
// Bytes complete on the synchronized 8th sclk rise; MISO shifts on falls that are not the byte-closing fall.
module aes_spi_frame_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs_n,
    input  logic         sclk,
    input  logic         mosi,
    output logic         miso,
    output logic         byte_done,
    output logic         busy,
    output logic         frame_error,
    output logic         core_start,
    output logic [127:0] core_text,
    output logic [255:0] core_key,
    output logic [1:0]   core_key_len,
    input  logic         core_done,
    input  logic [127:0] core_result
);

    typedef enum logic [2:0] {
        IDLE,
        RX_TEXT,
        RX_KSIZE,
        RX_KEY,
        RUN,
        TX_RESULT
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
    logic                   cs_prev_q, sclk_prev_q;
    logic                   cs_n_s, sclk_s, mosi_s;
    logic                   sclk_rise, sclk_fall, cs_rise, byte_end;
    logic [7:0]             rx_byte;

    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [5:0]     byte_cnt_q, byte_cnt_d;
    logic [5:0]     key_n_q, key_n_d;
    logic [5:0]     key_pos;
    logic [6:0]     res_base;
    logic [7:0]     rx_shift_q, rx_shift_d;
    logic [7:0]     tx_shift_q, tx_shift_d;
    logic [127:0]   res_q, res_d;
    logic [127:0]   core_text_q, core_text_d;
    logic [255:0]   core_key_q, core_key_d;
    logic [1:0]     core_key_len_q, core_key_len_d;
    logic           frame_error_q, frame_error_d;
    logic           byte_done_q, byte_done_d;
    logic           core_start_q, core_start_d;

    assign cs_n_s = cs_sync_q[SYNC_STAGES-1];
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_prev_q & ~cs_n_s;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_n_s & ~cs_prev_q;
    assign byte_end  = sclk_rise && (bit_cnt_q == 3'd7);
    assign rx_byte   = {rx_shift_q[6:0], mosi_s};

    assign key_pos  = key_n_q - byte_cnt_q - 6'd1;
    assign res_base = {4'd15 - byte_cnt_q[3:0], 3'b000};

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            cs_prev_q   <= cs_n_s;
            sclk_prev_q <= sclk_s;
        end
    end

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        byte_cnt_d     = byte_cnt_q;
        key_n_d        = key_n_q;
        rx_shift_d     = rx_shift_q;
        tx_shift_d     = tx_shift_q;
        res_d          = res_q;
        core_text_d    = core_text_q;
        core_key_d     = core_key_q;
        core_key_len_d = core_key_len_q;
        frame_error_d  = frame_error_q;
        byte_done_d    = 1'b0;
        core_start_d   = 1'b0;

        if (cs_rise) begin
            bit_cnt_d = 3'd0;
        end else if (sclk_rise) begin
            rx_shift_d = rx_byte;
            bit_cnt_d  = bit_cnt_q + 3'd1;
        end

        // The fall right after a byte boundary must not shift away the freshly loaded MSB.
        if (sclk_fall && (bit_cnt_q != 3'd0)) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
        end

        if (byte_end) begin
            byte_done_d = 1'b1;
            tx_shift_d  = 8'h00;
        end

        case (state_q)
            IDLE: begin
                if (byte_end) begin
                    core_text_d   = {rx_byte, 120'b0};
                    frame_error_d = 1'b0;
                    byte_cnt_d    = 6'd1;
                    state_d       = RX_TEXT;
                end
            end
            RX_TEXT: begin
                if (byte_end) begin
                    core_text_d[{4'd15 - byte_cnt_q[3:0], 3'b000} +: 8] = rx_byte;
                    if (byte_cnt_q == 6'd15) begin
                        byte_cnt_d = 6'd0;
                        state_d    = RX_KSIZE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 6'd1;
                    end
                end
            end
            RX_KSIZE: begin
                if (byte_end) begin
                    byte_cnt_d = 6'd0;
                    core_key_d = '0;
                    state_d    = RX_KEY;
                    case (rx_byte)
                        8'h10: begin core_key_len_d = 2'd0; key_n_d = 6'd16; end
                        8'h18: begin core_key_len_d = 2'd1; key_n_d = 6'd24; end
                        8'h20: begin core_key_len_d = 2'd2; key_n_d = 6'd32; end
                        default: begin
                            core_key_d    = core_key_q;
                            frame_error_d = 1'b1;
                            state_d       = IDLE;
                        end
                    endcase
                end
            end
            RX_KEY: begin
                if (byte_end) begin
                    core_key_d[{key_pos, 3'b000} +: 8] = rx_byte;
                    if (byte_cnt_q == key_n_q - 6'd1) begin
                        core_start_d = 1'b1;
                        byte_cnt_d   = 6'd0;
                        state_d      = RUN;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 6'd1;
                    end
                end
            end
            RUN: begin
                if (core_done) begin
                    res_d   = core_result;
                    state_d = TX_RESULT;
                    // byte_cnt counts result bytes already loaded into tx_shift.
                    if (byte_end || (bit_cnt_q == 3'd0 && !sclk_rise)) begin
                        tx_shift_d = core_result[127:120];
                        byte_cnt_d = 6'd1;
                    end else begin
                        byte_cnt_d = 6'd0;
                    end
                end
            end
            TX_RESULT: begin
                if (byte_end) begin
                    if (byte_cnt_q == 6'd16) begin
                        byte_cnt_d = 6'd0;
                        state_d    = IDLE;
                    end else begin
                        tx_shift_d = res_q[res_base +: 8];
                        byte_cnt_d = byte_cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            byte_cnt_q     <= '0;
            key_n_q        <= '0;
            rx_shift_q     <= '0;
            tx_shift_q     <= '0;
            res_q          <= '0;
            core_text_q    <= '0;
            core_key_q     <= '0;
            core_key_len_q <= '0;
            frame_error_q  <= 1'b0;
            byte_done_q    <= 1'b0;
            core_start_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            byte_cnt_q     <= byte_cnt_d;
            key_n_q        <= key_n_d;
            rx_shift_q     <= rx_shift_d;
            tx_shift_q     <= tx_shift_d;
            res_q          <= res_d;
            core_text_q    <= core_text_d;
            core_key_q     <= core_key_d;
            core_key_len_q <= core_key_len_d;
            frame_error_q  <= frame_error_d;
            byte_done_q    <= byte_done_d;
            core_start_q   <= core_start_d;
        end
    end

    assign miso         = tx_shift_q[7];
    assign byte_done    = byte_done_q;
    assign busy         = (state_q != IDLE);
    assign frame_error  = frame_error_q;
    assign core_start   = core_start_q;
    assign core_text    = core_text_q;
    assign core_key     = core_key_q;
    assign core_key_len = core_key_len_q;

endmodule

// File: tb/tb_aes_spi_frame_slave.sv
// tb/tb_aes_spi_frame_slave.sv - directed SPI frame bench with constant AES vectors as the core model.
module tb_aes_spi_frame_slave;

    localparam int HALF = 5;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] R192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] R128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset;
    logic         cs_n, sclk, mosi;
    logic         miso, byte_done, busy, frame_error, core_start;
    logic [127:0] core_text;
    logic [255:0] core_key;
    logic [1:0]   core_key_len;
    logic         core_done;
    logic [127:0] core_result;

    int n_compared   = 0;
    int n_mismatched = 0;
    int bd_cnt       = 0;
    int st_cnt       = 0;
    int bd0, st0;
    logic [7:0]   rb;
    logic [127:0] got;
    logic [15:0]  pend;

    aes_spi_frame_slave #(.SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso),
        .byte_done(byte_done), .busy(busy), .frame_error(frame_error), .core_start(core_start),
        .core_text(core_text), .core_key(core_key), .core_key_len(core_key_len),
        .core_done(core_done), .core_result(core_result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (byte_done)  bd_cnt <= bd_cnt + 1;
        if (core_start) st_cnt <= st_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            wait_clk(HALF);
            r = {r[6:0], miso};
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] b, output logic [7:0] r);
        spi_bits(b, 8, r);
    endtask

    task automatic xfer_cs(input logic [7:0] b, output logic [7:0] r);
        cs_n = 1'b0;
        wait_clk(HALF);
        spi_bits(b, 8, r);
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(HALF);
    endtask

    function automatic logic [7:0] pt_byte(input logic [127:0] pt, input int i);
        logic [127:0] t;
        t = pt >> (8 * (15 - i));
        return t[7:0];
    endfunction

    function automatic logic [7:0] key_byte(input logic [255:0] key, input int n, input int k);
        logic [255:0] t;
        t = key >> (8 * (n - 1 - k));
        return t[7:0];
    endfunction

    // Holds cs_n low for the whole frame; sends nsend of the n key bytes.
    task automatic send_rx_phase(input logic [127:0] pt, input logic [7:0] sz,
                                 input logic [255:0] key, input int n, input int nsend);
        logic [7:0] r;
        cs_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 16; i++) xfer(pt_byte(pt, i), r);
        xfer(sz, r);
        for (int k = 0; k < nsend; k++) xfer(key_byte(key, n, k), r);
    endtask

    task automatic end_frame();
        cs_n = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic core_finish(input logic [127:0] res);
        wait_clk(2);
        core_result = res;
        core_done = 1'b1;
        wait_clk(1);
        core_done = 1'b0;
        wait_clk(4);
    endtask

    task automatic read_result(output logic [127:0] r);
        logic [7:0] b;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            xfer(8'h00, b);
            r = {r[119:0], b};
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_miso", 256'(miso), 256'd0);
        check_eq("rst_byte_done", 256'(byte_done), 256'd0);
        check_eq("rst_busy", 256'(busy), 256'd0);
        check_eq("rst_frame_error", 256'(frame_error), 256'd0);
        check_eq("rst_core_start", 256'(core_start), 256'd0);
        check_eq("rst_core_text", 256'(core_text), 256'd0);
        check_eq("rst_core_key", core_key, 256'd0);
        check_eq("rst_core_key_len", 256'(core_key_len), 256'd0);
    endtask

    initial begin
        reset = 1'b1;
        cs_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        core_done = 1'b0;
        core_result = '0;
        wait_clk(3);
        check_reset_outputs();
        reset = 1'b0;
        wait_clk(3);

        core_finish(R256);
        check_eq("idle_core_done_busy", 256'(busy), 256'd0);

        // 256-bit frame
        bd0 = bd_cnt; st0 = st_cnt;
        send_rx_phase(PT, 8'h20, K256, 32, 32);
        check_eq("k256_rx_byte_done", 256'(bd_cnt - bd0), 256'd49);
        check_eq("k256_start_count", 256'(st_cnt - st0), 256'd1);
        check_eq("k256_busy_run", 256'(busy), 256'd1);
        check_eq("k256_key_len", 256'(core_key_len), 256'd2);
        check_eq("k256_key", core_key, K256);
        check_eq("k256_text", 256'(core_text), 256'(PT));
        core_finish(R256);
        read_result(got);
        end_frame();
        check_eq("k256_result", 256'(got), 256'(R256));
        check_eq("k256_tx_byte_done", 256'(bd_cnt - bd0), 256'd65);
        check_eq("k256_busy_end", 256'(busy), 256'd0);

        // 128-bit frame
        send_rx_phase(PT, 8'h10, K128, 16, 16);
        check_eq("k128_key_len", 256'(core_key_len), 256'd0);
        check_eq("k128_key", core_key, K128);
        core_finish(R128);
        read_result(got);
        end_frame();
        check_eq("k128_result", 256'(got), 256'(R128));

        // illegal key-size byte, then a good frame clears the error
        st0 = st_cnt;
        send_rx_phase(PT, 8'h11, K128, 16, 0);
        end_frame();
        check_eq("bad_size_error", 256'(frame_error), 256'd1);
        check_eq("bad_size_busy", 256'(busy), 256'd0);
        check_eq("bad_size_no_start", 256'(st_cnt - st0), 256'd0);
        send_rx_phase(PT, 8'h10, K128, 16, 16);
        check_eq("recover_error_clear", 256'(frame_error), 256'd0);
        core_finish(R128);
        read_result(got);
        end_frame();
        check_eq("recover_result", 256'(got), 256'(R128));

        // byte-per-cs framing with an aborted partial text byte 3
        bd0 = bd_cnt; st0 = st_cnt;
        for (int i = 0; i < 3; i++) xfer_cs(pt_byte(PT, i), rb);
        cs_n = 1'b0;
        wait_clk(HALF);
        spi_bits(8'hA5, 5, rb);
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(HALF);
        check_eq("abort_no_byte_done", 256'(bd_cnt - bd0), 256'd3);
        for (int i = 3; i < 16; i++) xfer_cs(pt_byte(PT, i), rb);
        xfer_cs(8'h10, rb);
        for (int k = 0; k < 16; k++) xfer_cs(key_byte(K128, 16, k), rb);
        check_eq("abort_text", 256'(core_text), 256'(PT));
        check_eq("abort_start", 256'(st_cnt - st0), 256'd1);
        core_finish(R128);
        cs_n = 1'b0;
        wait_clk(HALF);
        read_result(got);
        end_frame();
        check_eq("abort_result", 256'(got), 256'(R128));

        // reset after key byte 10 of a 192-bit frame
        send_rx_phase(PT, 8'h18, K192, 24, 11);
        reset = 1'b1;
        wait_clk(1);
        check_reset_outputs();
        reset = 1'b0;
        end_frame();
        send_rx_phase(PT, 8'h18, K192, 24, 24);
        check_eq("k192_key_len", 256'(core_key_len), 256'd1);
        check_eq("k192_key", core_key, K192);
        core_finish(R192);
        read_result(got);
        end_frame();
        check_eq("k192_result", 256'(got), 256'(R192));

        // master clocks two bytes before the core finishes
        send_rx_phase(PT, 8'h20, K256, 32, 32);
        xfer(8'hFF, rb);
        pend[15:8] = rb;
        xfer(8'hFF, rb);
        pend[7:0] = rb;
        check_eq("pending_zero_bytes", 256'(pend), 256'd0);
        check_eq("pending_busy", 256'(busy), 256'd1);
        core_finish(R256);
        read_result(got);
        end_frame();
        check_eq("pending_result", 256'(got), 256'(R256));
        check_eq("pending_busy_end", 256'(busy), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
